// File: rtl/heap_pkg.sv
// Shared definitions for the max-heap command interface and its batch sorter.
// Contents: heap op codes, heap size constants, sorter FSM state encodings.
package heap_pkg;

  localparam int unsigned HEAP_SIZE_W   = 5;
  localparam int unsigned MAX_HEAP_SIZE = 32;

  typedef logic [4:0] heap_op_t;

  localparam heap_op_t HEAP_OP_INIT = 5'd0;
  localparam heap_op_t HEAP_OP_PUSH = 5'd1;
  localparam heap_op_t HEAP_OP_POP  = 5'd2;
  localparam heap_op_t HEAP_OP_SORT = 5'd3;

  typedef logic [2:0] sorter_state_t;

  localparam sorter_state_t ST_IDLE    = 3'd0;
  localparam sorter_state_t ST_CLEAR   = 3'd1;
  localparam sorter_state_t ST_FILL    = 3'd2;
  localparam sorter_state_t ST_CHECK   = 3'd3;
  localparam sorter_state_t ST_DRAIN   = 3'd4;
  localparam sorter_state_t ST_POPWAIT = 3'd5;

endpackage

// File: rtl/heap_batch_sorter_if.sv
// Bundle of the sorter's input stream, output stream and heap command bus.
// master: the sorter side. slave: producer, consumer and heap side.
interface heap_batch_sorter_if #(
  parameter int unsigned DATA_W = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  logic              heap_en;
  logic [4:0]        heap_op;
  logic [DATA_W-1:0] heap_wdata;
  logic [4:0]        heap_size;
  logic [DATA_W-1:0] heap_top;

  modport master (
    input  in_valid, in_data, in_last, out_ready, heap_size, heap_top,
    output in_ready, out_valid, out_data, out_last, heap_en, heap_op, heap_wdata
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready, heap_size, heap_top,
    input  in_ready, out_valid, out_data, out_last, heap_en, heap_op, heap_wdata
  );

endinterface

// File: rtl/heap_wait_timer.sv
// Post-command wait timer for the heap interface.
// Ports: clk, reset (async, active-high), heap_en (command strobe),
//        idle (no command in flight and wait expired).
module heap_wait_timer #(
  parameter int unsigned HEAP_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic heap_en,
  output logic idle
);

  localparam int unsigned CNT_W = (HEAP_LAT < 2) ? 1 : $clog2(HEAP_LAT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (heap_en) begin
      cnt_q <= CNT_W'(HEAP_LAT);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // The strobe cycle itself counts as busy, so a new command can never be
  // issued back-to-back with the previous one.
  assign idle = !heap_en && (cnt_q == '0);

endmodule

// File: rtl/heap_batch_sorter.sv
// Batch sorter built on an external max-heap.
// Accepts a batch on the input stream, pushes every beat into the heap, then
// pops the heap and emits the values largest-first on the output stream.
// Ports: clk, reset (async, active-high), bus (streams + heap commands),
//        batch_trunc (pulse: batch closed at MAX_BATCH without in_last),
//        size_err (sticky heap_size/count disagreement), busy (not IDLE).
module heap_batch_sorter
  import heap_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BATCH = 31,
  parameter int unsigned HEAP_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  heap_batch_sorter_if.master bus,
  output logic                batch_trunc,
  output logic                size_err,
  output logic                busy
);

  sorter_state_t          state_q, state_d;
  logic [HEAP_SIZE_W-1:0] count_q, count_d;
  logic                   heap_en_q, heap_en_d;
  heap_op_t               heap_op_q, heap_op_d;
  logic [DATA_W-1:0]      heap_wdata_q, heap_wdata_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_W-1:0]      out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   trunc_q, trunc_d;
  logic                   size_err_q, size_err_d;

  logic                   timer_idle;
  logic                   in_accept;
  logic [HEAP_SIZE_W-1:0] count_inc;
  logic                   count_at_max;

  heap_wait_timer #(
    .HEAP_LAT(HEAP_LAT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .heap_en(heap_en_q),
    .idle   (timer_idle)
  );

  assign bus.in_ready  = (state_q == ST_FILL) && timer_idle;
  assign in_accept     = bus.in_valid && bus.in_ready;
  assign count_inc     = count_q + 1'b1;
  assign count_at_max  = (count_inc == HEAP_SIZE_W'(MAX_BATCH));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    heap_en_d    = 1'b0;
    heap_op_d    = heap_op_q;
    heap_wdata_d = heap_wdata_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    trunc_d      = 1'b0;
    size_err_d   = size_err_q;

    case (state_q)
      ST_IDLE: begin
        // The opening beat is left pending; it is accepted once FILL is reached.
        if (bus.in_valid) begin
          heap_en_d = 1'b1;
          heap_op_d = HEAP_OP_INIT;
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (timer_idle) begin
          count_d = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (in_accept) begin
          heap_en_d    = 1'b1;
          heap_op_d    = HEAP_OP_PUSH;
          heap_wdata_d = bus.in_data;
          count_d      = count_inc;
          trunc_d      = count_at_max && !bus.in_last;
          if (bus.in_last || count_at_max) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        // Drain by our own count even if the heap disagrees.
        if (timer_idle) begin
          if (bus.heap_size != count_q) begin
            size_err_d = 1'b1;
          end
          out_valid_d = 1'b1;
          out_data_d  = bus.heap_top;
          out_last_d  = (count_q == HEAP_SIZE_W'(1));
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          out_last_d  = 1'b0;
          heap_en_d   = 1'b1;
          heap_op_d   = HEAP_OP_POP;
          count_d     = count_q - 1'b1;
          state_d     = ST_POPWAIT;
        end
      end
      ST_POPWAIT: begin
        if (timer_idle) begin
          if (count_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = bus.heap_top;
            out_last_d  = (count_q == HEAP_SIZE_W'(1));
            state_d     = ST_DRAIN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      heap_en_q    <= 1'b0;
      heap_op_q    <= HEAP_OP_INIT;
      heap_wdata_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      trunc_q      <= 1'b0;
      size_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      heap_en_q    <= heap_en_d;
      heap_op_q    <= heap_op_d;
      heap_wdata_q <= heap_wdata_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      trunc_q      <= trunc_d;
      size_err_q   <= size_err_d;
    end
  end

  assign bus.heap_en    = heap_en_q;
  assign bus.heap_op    = heap_op_q;
  assign bus.heap_wdata = heap_wdata_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign batch_trunc    = trunc_q;
  assign size_err       = size_err_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_heap_batch_sorter.sv
// Directed bench for heap_batch_sorter with a behavioural max-heap model.
module tb_heap_batch_sorter;
  import heap_pkg::*;

  localparam int DW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic batch_trunc;
  logic size_err;
  logic busy;

  heap_batch_sorter_if #(.DATA_W(DW)) bus ();

  heap_batch_sorter #(
    .DATA_W   (DW),
    .MAX_BATCH(31),
    .HEAP_LAT (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .batch_trunc(batch_trunc),
    .size_err   (size_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Heap model: unsorted storage, root is the running maximum.
  logic [DW-1:0] hmem [MAX_HEAP_SIZE];
  int            hsize;
  int            size_bias;
  logic [DW-1:0] mtop;

  always_comb begin
    mtop = '0;
    for (int i = 0; i < MAX_HEAP_SIZE; i++) begin
      if (i < hsize && hmem[i] > mtop) mtop = hmem[i];
    end
  end

  assign bus.heap_top  = mtop;
  assign bus.heap_size = 5'(hsize - size_bias);

  function automatic int max_idx();
    int k = 0;
    for (int i = 1; i < MAX_HEAP_SIZE; i++) begin
      if (i < hsize && hmem[i] > hmem[k]) k = i;
    end
    return k;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hsize <= 0;
    end else if (bus.heap_en) begin
      case (bus.heap_op)
        HEAP_OP_INIT: hsize <= 0;
        HEAP_OP_PUSH: if (hsize < MAX_HEAP_SIZE) begin
          hmem[hsize] <= bus.heap_wdata;
          hsize       <= hsize + 1;
        end
        HEAP_OP_POP: if (hsize > 0) begin
          hmem[max_idx()] <= hmem[hsize-1];
          hsize           <= hsize - 1;
        end
        default: ;
      endcase
    end
  end

  // Logs of heap commands, output beats and truncation pulses.
  logic [4:0]    cmd_log  [$];
  logic [DW-1:0] out_log  [$];
  logic          last_log [$];
  int            trunc_cnt;

  always @(posedge clk) begin
    if (!reset) begin
      if (bus.heap_en) cmd_log.push_back(bus.heap_op);
      if (bus.out_valid && bus.out_ready) begin
        out_log.push_back(bus.out_data);
        last_log.push_back(bus.out_last);
      end
      if (batch_trunc) trunc_cnt++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    cmd_log.delete();
    out_log.delete();
    last_log.delete();
    trunc_cnt = 0;
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send(input logic [DW-1:0] d, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check({tag, "_idle_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({tag, "_valid_timeout"}, 64'd1, 64'd0);
  endtask

  logic [DW-1:0] exp_d [32];

  task automatic check_outs(input string tag, input int n);
    check({tag, "_nbeats"}, 64'(out_log.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < out_log.size()) begin
        check($sformatf("%s_data%0d", tag, i), 64'(out_log[i]), 64'(exp_d[i]));
        check($sformatf("%s_last%0d", tag, i), 64'(last_log[i]), 64'(i == n - 1));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"},   64'(bus.in_ready),   64'd0);
    check({tag, "_out_valid"},  64'(bus.out_valid),  64'd0);
    check({tag, "_out_data"},   64'(bus.out_data),   64'd0);
    check({tag, "_out_last"},   64'(bus.out_last),   64'd0);
    check({tag, "_heap_en"},    64'(bus.heap_en),    64'd0);
    check({tag, "_heap_op"},    64'(bus.heap_op),    64'd0);
    check({tag, "_heap_wdata"}, 64'(bus.heap_wdata), 64'd0);
    check({tag, "_trunc"},      64'(batch_trunc),    64'd0);
    check({tag, "_size_err"},   64'(size_err),       64'd0);
    check({tag, "_busy"},       64'(busy),           64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    size_bias     = 0;
    clear_logs();

    repeat (2) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    // Basic 4-value batch.
    clear_logs();
    send(5, 0); send(1, 0); send(9, 0); send(3, 1);
    wait_idle("t1");
    check("t1_ncmd", 64'(cmd_log.size()), 64'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < cmd_log.size())
        check($sformatf("t1_cmd%0d", i), 64'(cmd_log[i]),
              64'(i == 0 ? HEAP_OP_INIT : (i < 5 ? HEAP_OP_PUSH : HEAP_OP_POP)));
    end
    exp_d[0] = 9; exp_d[1] = 5; exp_d[2] = 3; exp_d[3] = 1;
    check_outs("t1", 4);
    check("t1_trunc", 64'(trunc_cnt), 64'd0);
    check("t1_size_err", 64'(size_err), 64'd0);

    // Single-beat batch.
    clear_logs();
    send(42, 1);
    wait_idle("t2");
    check("t2_ncmd", 64'(cmd_log.size()), 64'd3);
    exp_d[0] = 42;
    check_outs("t2", 1);
    check("t2_busy", 64'(busy), 64'd0);

    // Truncated full batch, then a fresh batch.
    clear_logs();
    for (int v = 1; v <= 31; v++) send(DW'(v), 0);
    wait_idle("t3");
    check("t3_trunc", 64'(trunc_cnt), 64'd1);
    for (int i = 0; i < 31; i++) exp_d[i] = DW'(31 - i);
    check_outs("t3", 31);
    clear_logs();
    send(32, 1);
    wait_idle("t3b");
    check("t3b_ncmd", 64'(cmd_log.size()), 64'd3);
    if (cmd_log.size() > 0) check("t3b_first_init", 64'(cmd_log[0]), 64'(HEAP_OP_INIT));
    exp_d[0] = 32;
    check_outs("t3b", 1);
    check("t3b_trunc", 64'(trunc_cnt), 64'd0);

    // Downstream stall during drain.
    clear_logs();
    bus.out_ready = 1'b0;
    send(4, 0); send(8, 0); send(6, 1);
    wait_out_valid("t4");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t4_stall_data%0d", i), 64'(bus.out_data), 64'd8);
      check($sformatf("t4_stall_last%0d", i), 64'(bus.out_last), 64'd0);
      check($sformatf("t4_stall_en%0d", i),   64'(bus.heap_en),  64'd0);
    end
    bus.out_ready = 1'b1;
    wait_idle("t4");
    exp_d[0] = 8; exp_d[1] = 6; exp_d[2] = 4;
    check_outs("t4", 3);

    // Heap under-reports its size.
    clear_logs();
    size_bias = 1;
    send(10, 0); send(20, 0); send(30, 0); send(40, 1);
    wait_idle("t5");
    check("t5_size_err", 64'(size_err), 64'd1);
    exp_d[0] = 40; exp_d[1] = 30; exp_d[2] = 20; exp_d[3] = 10;
    check_outs("t5", 4);
    size_bias = 0;
    clear_logs();
    send(2, 1);
    wait_idle("t5b");
    check("t5b_size_err_sticky", 64'(size_err), 64'd1);
    exp_d[0] = 2;
    check_outs("t5b", 1);

    // Reset in the middle of a drain.
    clear_logs();
    bus.out_ready = 1'b0;
    send(3, 0); send(1, 0); send(4, 0); send(1, 0);
    send(5, 0); send(9, 0); send(2, 0); send(6, 1);
    wait_out_valid("t6");
    check("t6_top_before_rst", 64'(bus.out_data), 64'd9);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("t6_rst");
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    clear_logs();
    @(negedge clk);
    send(7, 0); send(2, 1);
    wait_idle("t6b");
    if (cmd_log.size() > 0) check("t6b_first_init", 64'(cmd_log[0]), 64'(HEAP_OP_INIT));
    exp_d[0] = 7; exp_d[1] = 2;
    check_outs("t6b", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
